// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses, exception codes and register field positions.
// Used by the CP0 unit and by the decode/M-stage exception detectors.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_SR       = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int SR_IM_LSB     = 10;
    localparam int SR_IM_MSB     = 15;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IE_BIT     = 0;
    localparam int CAUSE_BD_BIT  = 31;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_IP_MSB  = 15;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_EXC_MSB = 6;

    // EPC is word aligned; the low two bits never hold state.
    localparam logic [31:0] EPC_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl, input logic ie);
        logic [31:0] r;
        r = '0;
        r[SR_IM_MSB:SR_IM_LSB] = im;
        r[SR_EXL_BIT]          = exl;
        r[SR_IE_BIT]           = ie;
        return r;
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip, input logic [4:0] exc);
        logic [31:0] r;
        r = '0;
        r[CAUSE_BD_BIT]                = bd;
        r[CAUSE_IP_MSB:CAUSE_IP_LSB]   = ip;
        r[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = exc;
        return r;
    endfunction

endpackage

// File: rtl/cp0_exc_unit.sv
// M-stage coprocessor 0: SR/Cause/EPC/PRId, exception request, mfc0 read; CP0_BADVADDR_EN adds BadVAddr (reg 8).
// Latency: Req and M_CP0Out are combinational; register updates are visible the cycle after the edge.
// Backpressure: none; Req is a request the pipeline must honour in the same cycle.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h2021_0601,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_PC,
    input  logic        M_BD,
    input  logic [4:0]  M_ExcCode,
    input  logic [31:0] M_BadAddr,
    input  logic [5:0]  HWInt,
    input  logic        WrEn,
    input  logic [4:0]  CP0Addr,
    input  logic [31:0] CP0In,
    input  logic        Eret,
    output logic [31:0] M_CP0Out,
    output logic [31:0] EPC,
    output logic [31:0] HandlerPC,
    output logic        Req
);

    logic [5:0]  sr_im_q, sr_im_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_ie_q, sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q, cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [4:0]  exc_code;
    logic [31:0] badvaddr_rd;

    // Interrupts use the live lines; the registered IP copy is only for software visibility.
    assign int_req  = sr_ie_q & ~sr_exl_q & (|(HWInt & sr_im_q));
    assign exc_req  = ~sr_exl_q & (M_ExcCode != EXC_INT);
    assign req      = reset & (int_req | exc_req);
    assign exc_code = int_req ? EXC_INT : M_ExcCode;

    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = HWInt;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        if (req) begin
            sr_exl_d    = 1'b1;
            cause_bd_d  = M_BD;
            cause_exc_d = exc_code;
            epc_d       = (M_BD ? (M_PC - 32'd4) : M_PC) & EPC_MASK;
        end else begin
            if (WrEn) begin
                case (CP0Addr)
                    CP0_SR: begin
                        sr_im_d  = CP0In[SR_IM_MSB:SR_IM_LSB];
                        sr_exl_d = CP0In[SR_EXL_BIT];
                        sr_ie_d  = CP0In[SR_IE_BIT];
                    end
                    CP0_EPC: epc_d = CP0In & EPC_MASK;
                    default: ;
                endcase
            end
            // Eret after the write so a simultaneous mtc0 SR cannot re-set EXL.
            if (Eret) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im_q     <= '0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
            epc_q       <= '0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr_q, badvaddr_d;

    always_comb begin
        badvaddr_d = badvaddr_q;
        if (req && ((exc_code == EXC_ADEL) || (exc_code == EXC_ADES))) begin
            badvaddr_d = M_BadAddr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            badvaddr_q <= '0;
        end else begin
            badvaddr_q <= badvaddr_d;
        end
    end

    assign badvaddr_rd = badvaddr_q;
`else
    logic [31:0] bad_addr_unused;
    assign bad_addr_unused = M_BadAddr;
    assign badvaddr_rd     = '0;
`endif

    always_comb begin
        case (CP0Addr)
            CP0_SR:       M_CP0Out = pack_sr(sr_im_q, sr_exl_q, sr_ie_q);
            CP0_CAUSE:    M_CP0Out = pack_cause(cause_bd_q, cause_ip_q, cause_exc_q);
            CP0_EPC:      M_CP0Out = epc_q;
            CP0_PRID:     M_CP0Out = PRID_VALUE;
            CP0_BADVADDR: M_CP0Out = badvaddr_rd;
            default:      M_CP0Out = '0;
        endcase
    end

    assign EPC       = epc_q;
    assign HandlerPC = HANDLER_PC;
    assign Req       = req;

endmodule
